// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator: eq/lt/gt, A-zero flag and bit-cycle count.
// Define SERIAL_CMP_SIGNED_EN to treat operands as two's complement.
module serial_magnitude_comparator #(
  parameter int WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic                         eq,
  output logic                         lt,
  output logic                         gt,
  output logic                         a_zero,
  output logic [$clog2(WIDTH+1)-1:0]   cycles
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             bit_a, bit_b, bit_diff, idx_last;
  logic [1:0]       pol;

  assign bit_a    = a_q[idx];
  assign bit_b    = b_q[idx];
  assign bit_diff = bit_a ^ bit_b;
  assign idx_last = (idx == '0);

  // {lt, gt} when the current bit pair differs; the sign bit flips polarity in signed mode
  always_comb begin
`ifdef SERIAL_CMP_SIGNED_EN
    pol = (idx == IW'(WIDTH-1)) ? {bit_a, bit_b} : {bit_b, bit_a};
`else
    pol = {bit_b, bit_a};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (bit_diff || idx_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      a_zero <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            a_zero <= ~|a;
            idx    <= IW'(WIDTH-1);
            eq     <= 1'b0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            cycles <= '0;
          end
        end
        SCAN: begin
          cycles <= cycles + CW'(1);
          if (bit_diff) begin
            lt <= pol[1];
            gt <= pol[0];
          end else if (idx_last) begin
            eq <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: 6-bit and 16-bit instances, arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_serial_magnitude_comparator;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  localparam int EQ = 0;
  localparam int LT = 1;
  localparam int GT = 2;

  typedef struct packed {
    logic       e;
    logic       l;
    logic       g;
    logic       z;
    logic [7:0] k;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start6, start16;
  logic [5:0]  a6, b6;
  logic [15:0] a16, b16;

  logic        busy6, done6, eq6, lt6, gt6, az6;
  logic [2:0]  cyc6;
  logic        busy16, done16, eq16, lt16, gt16, az16;
  logic [4:0]  cyc16;

  serial_magnitude_comparator #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .a(a6), .b(b6),
    .busy(busy6), .done(done6), .eq(eq6), .lt(lt6), .gt(gt6),
    .a_zero(az6), .cycles(cyc6)
  );

  serial_magnitude_comparator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .eq(eq16), .lt(lt16), .gt(gt16),
    .a_zero(az16), .cycles(cyc16)
  );

  // {busy, done, eq, lt, gt, a_zero, cycles[7:0]}
  logic [13:0] obs [2];
  assign obs[0] = {busy6,  done6,  eq6,  lt6,  gt6,  az6,  5'b0, cyc6};
  assign obs[1] = {busy16, done16, eq16, lt16, gt16, az16, 3'b0, cyc16};

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  // Expected outcome straight from the arithmetic: compare as numbers, and the bit count
  // is the number of leading equal bits plus the first differing one.
  function automatic res_t model(input int av, input int bv, input int w);
    res_t r;
    int   x, sa, sb;
    x = av ^ bv;
    r.z = (av == 0);
    if (x == 0) begin
      r.e = 1'b1; r.l = 1'b0; r.g = 1'b0;
      r.k = 8'(w);
    end else begin
      r.e = 1'b0;
      r.k = 8'(w - ($clog2(x + 1) - 1));
      if (SGN) begin
        sa = av - ((av >> (w - 1)) & 1) * (1 << w);
        sb = bv - ((bv >> (w - 1)) & 1) * (1 << w);
        r.l = (sa < sb);
      end else begin
        r.l = (av < bv);
      end
      r.g = ~r.l;
    end
    return r;
  endfunction

  res_t pre [2];
  logic st  [2];
  always_comb begin
    pre[0] = model(int'(a6), int'(b6), 6);
    pre[1] = model(int'(a16), int'(b16), 16);
    st[0]  = start6;
    st[1]  = start16;
  end

  res_t r_q    [2];
  bit   m_busy [2];
  bit   m_done [2];
  bit   m_eq   [2];
  bit   m_lt   [2];
  bit   m_gt   [2];
  bit   m_az   [2];
  int   m_cyc  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_eq[i] <= 1'b0;
        m_lt[i]   <= 1'b0; m_gt[i]   <= 1'b0; m_az[i] <= 1'b0;
        m_cyc[i]  <= 0;    r_q[i]    <= '0;
      end else if (m_done[i]) begin
        m_done[i] <= 1'b0;
      end else if (m_busy[i]) begin
        m_cyc[i] <= m_cyc[i] + 1;
        if (m_cyc[i] + 1 == int'(r_q[i].k)) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_eq[i]   <= r_q[i].e;
          m_lt[i]   <= r_q[i].l;
          m_gt[i]   <= r_q[i].g;
        end
      end else if (st[i]) begin
        r_q[i]    <= pre[i];
        m_busy[i] <= 1'b1;
        m_cyc[i]  <= 0;
        m_eq[i]   <= 1'b0;
        m_lt[i]   <= 1'b0;
        m_gt[i]   <= 1'b0;
        m_az[i]   <= pre[i].z;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [13:0] want;
        want = {m_busy[i], m_done[i], m_eq[i], m_lt[i], m_gt[i], m_az[i], 8'(m_cyc[i])};
        n_chk++;
        if (obs[i] !== want) begin
          n_fail++;
          $display("FAIL model_cmp inst%0d at %0t: got %h, expected %h", i, $time, obs[i], want);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [15:0] av, input logic [15:0] bv);
    if (sel == 0) begin
      start6 = s; a6 = av[5:0]; b6 = bv[5:0];
    end else begin
      start16 = s; a16 = av; b16 = bv;
    end
  endtask

  // One comparison; inj>0 pulses start with different operands inj cycles into the scan.
  task automatic run(input int sel, input logic [15:0] av, input logic [15:0] bv,
                     input int want_cmp, input int want_k, input int want_z, input int inj);
    int n;
    bit seen;
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    @(negedge clk);
    drive(sel, 1'b0, av, bv);
    chk("busy_after_start", int'(obs[sel][13]), 1);
    chk("a_zero_after_start", int'(obs[sel][8]), want_z);
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (inj > 0 && n == inj) drive(sel, 1'b1, ~av, av);
      else if (inj > 0 && n == inj + 1) drive(sel, 1'b0, av, bv);
      if (obs[sel][12]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", n, want_k);
    chk("busy_in_done", int'(obs[sel][13]), 0);
    chk("eq", int'(obs[sel][11]), int'(want_cmp == EQ));
    chk("lt", int'(obs[sel][10]), int'(want_cmp == LT));
    chk("gt", int'(obs[sel][9]),  int'(want_cmp == GT));
    chk("cycles", int'(obs[sel][7:0]), want_k);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    int   dn;
    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk("reset_state_w6", int'(obs[0]), 0);
    chk("reset_state_w16", int'(obs[1]), 0);

    r = model(42, 10, 6);
    chk("model_msb_k", int'(r.k), 1);
    chk("model_msb_lt", int'(r.l), int'(SGN));
    r = model(3, 1, 6);
    chk("model_3v1_k", int'(r.k), 5);
    chk("model_3v1_gt", int'(r.g), 1);
    r = model(32768, 32767, 16);
    chk("model_8000_k", int'(r.k), 1);
    r = model(255, 256, 16);
    chk("model_00ff_k", int'(r.k), 8);
    r = model(5, 5, 6);
    chk("model_eq_k", int'(r.k), 6);

    @(negedge clk);
    rst_n = 1'b1;

    run(0, 16'h00, 16'h00, EQ, 6, 1, 0);
    run(0, 16'h2A, 16'h0A, SGN ? LT : GT, 1, 0, 0);
    run(0, 16'h03, 16'h01, GT, 5, 0, 0);
    run(0, 16'h01, 16'h03, LT, 5, 0, 0);
    run(0, 16'h00, 16'h00, EQ, 6, 1, 2);
    run(0, 16'h30, 16'h20, GT, 2, 0, 0);

    // asynchronous abort mid-scan
    @(negedge clk);
    drive(0, 1'b1, 16'h07, 16'h07);
    @(negedge clk);
    drive(0, 1'b0, 16'h07, 16'h07);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'(obs[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (obs[0][12]) dn++;
    end
    chk("no_done_after_abort", dn, 0);
    run(0, 16'h3F, 16'h3F, EQ, 6, 0, 0);

    run(1, 16'h8000, 16'h7FFF, SGN ? LT : GT, 1, 0, 0);
    run(1, 16'h00FF, 16'h0100, LT, 8, 0, 0);
    run(1, 16'hFFFF, 16'hFFFE, GT, 16, 0, 0);
    run(1, 16'h0000, 16'h0001, LT, 16, 1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
